display7s_mux: RTL

- Time-multiplexed driver for an N-digit 7-segment display with shared segment lines and one enable line per digit.
- Successor to the single-digit BCD decoder. Adds parametrised digit count, hex/decimal mode, selectable output polarity, leading-zero suppression, decimal points, an anti-ghosting blank window and frame-coherent input capture.
- Sits between the datapath (counters, measurement values) and the board display pins.

---
 rtl/display7s_pkg.sv | 38 +++
 rtl/display7s_if.sv | 23 ++
 rtl/seg7_hex_dec.sv | 32 +++
 rtl/display7s_mux.sv | 104 ++++++++++
 4 files changed

// File: rtl/display7s_pkg.sv
// Shared constants for the multiplexed 7-segment driver.
// Segment patterns are gfedcba and active-high.
package display7s_pkg;

  localparam int DEF_N_DIG = 4;
  localparam int DEF_PRESC = 50000;

  localparam logic [6:0] SEG_0    = 7'b0111111;
  localparam logic [6:0] SEG_1    = 7'b0000110;
  localparam logic [6:0] SEG_2    = 7'b1011011;
  localparam logic [6:0] SEG_3    = 7'b1001111;
  localparam logic [6:0] SEG_4    = 7'b1100110;
  localparam logic [6:0] SEG_5    = 7'b1101101;
  localparam logic [6:0] SEG_6    = 7'b1111101;
  localparam logic [6:0] SEG_7    = 7'b0000111;
  localparam logic [6:0] SEG_8    = 7'b1111111;
  localparam logic [6:0] SEG_9    = 7'b1101111;
  localparam logic [6:0] SEG_A    = 7'b1110111;
  localparam logic [6:0] SEG_B    = 7'b1111100;
  localparam logic [6:0] SEG_C    = 7'b0111001;
  localparam logic [6:0] SEG_D    = 7'b1011110;
  localparam logic [6:0] SEG_E    = 7'b1111001;
  localparam logic [6:0] SEG_F    = 7'b1110001;
  localparam logic [6:0] SEG_DASH = 7'b1000000;
  localparam logic [6:0] SEG_OFF  = 7'b0000000;

  function automatic int cnt_width(input int presc);
    return (presc <= 2) ? 1 : $clog2(presc);
  endfunction

  function automatic int idx_width(input int n_dig);
    return (n_dig <= 2) ? 1 : $clog2(n_dig);
  endfunction

  localparam int DEF_CNT_W = cnt_width(DEF_PRESC);
  localparam int DEF_IDX_W = idx_width(DEF_N_DIG);

endpackage

// File: rtl/display7s_if.sv
// Datapath-side inputs and board-side outputs of the display driver.
interface display7s_if #(
  parameter int N_DIG = 4
) ();
  logic               en;
  logic [4*N_DIG-1:0] valor;
  logic [N_DIG-1:0]   dp;
  logic               blank_lz;
  logic [6:0]         segmentos;
  logic               punto;
  logic [N_DIG-1:0]   anodos;
  logic               frame_tick;

  modport master (
    output en, valor, dp, blank_lz,
    input  segmentos, punto, anodos, frame_tick
  );

  modport slave (
    input  en, valor, dp, blank_lz,
    output segmentos, punto, anodos, frame_tick
  );
endinterface

// File: rtl/seg7_hex_dec.sv
// Code to active-high gfedcba pattern; codes 10-15 show a dash unless HEX_EN.
module seg7_hex_dec
  import display7s_pkg::*;
#(
  parameter bit HEX_EN = 1'b1
) (
  input  logic [3:0] code,
  output logic [6:0] pattern
);
  always_comb begin
    pattern = SEG_OFF;
    unique case (code)
      4'd0:  pattern = SEG_0;
      4'd1:  pattern = SEG_1;
      4'd2:  pattern = SEG_2;
      4'd3:  pattern = SEG_3;
      4'd4:  pattern = SEG_4;
      4'd5:  pattern = SEG_5;
      4'd6:  pattern = SEG_6;
      4'd7:  pattern = SEG_7;
      4'd8:  pattern = SEG_8;
      4'd9:  pattern = SEG_9;
      4'd10: pattern = HEX_EN ? SEG_A : SEG_DASH;
      4'd11: pattern = HEX_EN ? SEG_B : SEG_DASH;
      4'd12: pattern = HEX_EN ? SEG_C : SEG_DASH;
      4'd13: pattern = HEX_EN ? SEG_D : SEG_DASH;
      4'd14: pattern = HEX_EN ? SEG_E : SEG_DASH;
      4'd15: pattern = HEX_EN ? SEG_F : SEG_DASH;
      default: pattern = SEG_OFF;
    endcase
  end
endmodule

// File: rtl/display7s_mux.sv
// Time-multiplexed N-digit 7-segment driver with per-frame input capture,
// leading-zero suppression and a blank window at the start of each slot.
module display7s_mux
  import display7s_pkg::*;
#(
  parameter int N_DIG       = DEF_N_DIG,
  parameter int PRESC       = DEF_PRESC,
  parameter int BLANK_CYC   = 2,
  parameter int HEX_EN      = 1,
  parameter int SEG_ACT_LOW = 1,
  parameter int AN_ACT_LOW  = 1
) (
  input logic        clk,
  input logic        rst_n,
  display7s_if.slave bus
);
  localparam int   CNT_W   = cnt_width(PRESC);
  localparam int   IDX_W   = idx_width(N_DIG);
  localparam logic SEG_INV = (SEG_ACT_LOW != 0);
  localparam logic AN_INV  = (AN_ACT_LOW != 0);

  logic [CNT_W-1:0]   cnt_reg, cnt_next;
  logic [IDX_W-1:0]   idx_reg, idx_next;
  logic [4*N_DIG-1:0] sh_valor_reg;
  logic [N_DIG-1:0]   sh_dp_reg;
  logic [6:0]         seg_reg, seg_next;
  logic               punto_reg, punto_next;
  logic [N_DIG-1:0]   an_reg, an_next;
  logic               tick_reg;
  logic               load;
  logic               run;

  logic [6:0]       pat [N_DIG];
  logic [N_DIG-1:0] sup;

  generate
    for (genvar gi = 0; gi < N_DIG; gi++) begin : g_dec
      seg7_hex_dec #(.HEX_EN(HEX_EN != 0)) u_dec (
        .code    (sh_valor_reg[4*gi +: 4]),
        .pattern (pat[gi])
      );
    end
  endgenerate

  // A digit is suppressed while it and every digit above it are a plain zero.
  always_comb begin
    sup = '0;
    run = bus.blank_lz;
    for (int i = N_DIG - 1; i >= 1; i--) begin
      run    = run && (sh_valor_reg[4*i +: 4] == 4'd0) && !sh_dp_reg[i];
      sup[i] = run;
    end
  end

  always_comb begin
    load       = bus.en && (cnt_reg == '0) && (idx_reg == '0);
    cnt_next   = cnt_reg;
    idx_next   = idx_reg;
    seg_next   = SEG_OFF;
    punto_next = 1'b0;
    an_next    = '0;
    if (bus.en) begin
      seg_next   = sup[idx_reg] ? SEG_OFF : pat[idx_reg];
      punto_next = sh_dp_reg[idx_reg] && !sup[idx_reg];
      if (cnt_reg >= CNT_W'(BLANK_CYC))
        an_next[idx_reg] = 1'b1;
      if (cnt_reg == CNT_W'(PRESC - 1)) begin
        cnt_next = '0;
        idx_next = (idx_reg == IDX_W'(N_DIG - 1)) ? '0 : idx_reg + 1'b1;
      end else begin
        cnt_next = cnt_reg + 1'b1;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      cnt_reg      <= '0;
      idx_reg      <= '0;
      sh_valor_reg <= '0;
      sh_dp_reg    <= '0;
      seg_reg      <= {7{SEG_INV}};
      punto_reg    <= SEG_INV;
      an_reg       <= {N_DIG{AN_INV}};
      tick_reg     <= 1'b0;
    end else begin
      cnt_reg   <= cnt_next;
      idx_reg   <= idx_next;
      seg_reg   <= seg_next ^ {7{SEG_INV}};
      punto_reg <= punto_next ^ SEG_INV;
      an_reg    <= an_next ^ {N_DIG{AN_INV}};
      tick_reg  <= load;
      if (load) begin
        sh_valor_reg <= bus.valor;
        sh_dp_reg    <= bus.dp;
      end
    end
  end

  assign bus.segmentos  = seg_reg;
  assign bus.punto      = punto_reg;
  assign bus.anodos     = an_reg;
  assign bus.frame_tick = tick_reg;
endmodule
